// File: rtl/pcie_egress_merge.sv
// -----------------------------------------------------------------------------
// pcie_egress_merge
//
// Merges four show-ahead per-port source FIFOs into one internal output FIFO.
// A round-robin arbiter pops at most one source per cycle. The popped word is
// tagged with its source index in bits [9:8] and written into the output FIFO
// on the same edge. Arbitration pauses while the output FIFO is almost full.
//
// Ports
//   clk               rising-edge clock for all state
//   reset             asynchronous, active-high reset
//   in_empty[3:0]     empty flags of the source FIFOs (bit i = port i)
//   in_data0..3       show-ahead head words of the source FIFOs
//   in_pop[3:0]       one-hot (or zero) pop to the source FIFOs, combinational
//   out_pop           downstream read request for the output FIFO
//   out_data          show-ahead head word of the output FIFO (0 while empty)
//   out_empty/out_full/out_almost_full/out_almost_empty
//                     flags decoded from the registered occupancy
//   error             sticky: pop while empty, or write attempt while full
//   fwd_count[4:0]    words forwarded, wrapping modulo 32
// -----------------------------------------------------------------------------
module pcie_egress_merge #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            in_empty,
    input  logic [DATA_WIDTH-1:0] in_data0,
    input  logic [DATA_WIDTH-1:0] in_data1,
    input  logic [DATA_WIDTH-1:0] in_data2,
    input  logic [DATA_WIDTH-1:0] in_data3,
    output logic [3:0]            in_pop,
    input  logic                  out_pop,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_empty,
    output logic                  out_full,
    output logic                  out_almost_full,
    output logic                  out_almost_empty,
    output logic                  error,
    output logic [4:0]            fwd_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    // Bits [9:8] of every word carry the source port index.
    localparam logic [DATA_WIDTH-1:0] TAG_MASK = DATA_WIDTH'(12'h300);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_ACTIVE,
        ST_PAUSE
    } state_t;

    state_t                  state_reg, state_next;
    logic [1:0]              last_grant_reg;
    logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [OCC_W-1:0]        occ_reg;
    logic [4:0]              fwd_count_reg;
    logic                    error_reg;
    logic [DATA_WIDTH-1:0]   head_reg, head_next;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [DATA_WIDTH-1:0]   in_word     [4];
    logic [DATA_WIDTH-1:0]   tagged_word [4];
    logic [1:0]              scan_idx;
    logic [1:0]              grant_idx;
    logic                    grant_valid;
    logic                    pop_allowed;
    logic                    wr_req, wr_en, rd_en;
    logic [DATA_WIDTH-1:0]   wr_word;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_word[0] = in_data0;
    assign in_word[1] = in_data1;
    assign in_word[2] = in_data2;
    assign in_word[3] = in_data3;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_tag
            assign tagged_word[gi] = (in_word[gi] & ~TAG_MASK) | (DATA_WIDTH'(gi) << 8);
        end
    endgenerate

    // Status flags come from the registered occupancy only.
    assign out_empty        = (occ_reg == '0);
    assign out_full         = (occ_reg == OCC_W'(DEPTH));
    assign out_almost_empty = (occ_reg <= OCC_W'(1));
    assign out_almost_full  = (occ_reg >= OCC_W'(AF_THRESH));

    // The almost-full term also blocks the ACTIVE cycle in which occupancy
    // first reaches the threshold, before the state register has moved to
    // PAUSE; otherwise one extra word would slip in past the threshold.
    assign pop_allowed = (state_reg == ST_ACTIVE) && !out_almost_full;

    // Round-robin: scan offsets 4..1 from last_grant so that the smallest
    // offset (last_grant+1) is evaluated last and therefore wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = last_grant_reg;
        scan_idx    = '0;
        for (int k = 4; k >= 1; k--) begin
            scan_idx = last_grant_reg + 2'(k);
            if (!in_empty[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        in_pop = 4'b0000;
        if (pop_allowed && grant_valid) begin
            in_pop[grant_idx] = 1'b1;
        end
    end

    assign wr_req  = pop_allowed && grant_valid;
    assign wr_en   = wr_req && !out_full;
    assign rd_en   = out_pop && !out_empty;
    assign wr_word = tagged_word[grant_idx];

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_INIT:   state_next = ST_ACTIVE;
            ST_ACTIVE: if (out_almost_full)  state_next = ST_PAUSE;
            ST_PAUSE:  if (!out_almost_full) state_next = ST_ACTIVE;
            default:   state_next = ST_INIT;
        endcase
    end

    // Registered show-ahead head: fetch the word the read pointer will point
    // at next cycle, bypassing the array when that slot is being written now.
    assign rd_ptr_next = rd_en ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;

    always_comb begin
        head_next = mem[rd_ptr_next];
        if (wr_en && (wr_ptr_reg == rd_ptr_next)) begin
            head_next = wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_INIT;
            last_grant_reg <= 2'd3;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            occ_reg        <= '0;
            fwd_count_reg  <= '0;
            error_reg      <= 1'b0;
            head_reg       <= '0;
        end else begin
            state_reg <= state_next;
            head_reg  <= head_next;
            if (wr_req) begin
                last_grant_reg <= grant_idx;
            end
            if (wr_en) begin
                wr_ptr_reg    <= ptr_inc(wr_ptr_reg);
                fwd_count_reg <= fwd_count_reg + 5'd1;
            end
            rd_ptr_reg <= rd_ptr_next;
            case ({wr_en, rd_en})
                2'b10:   occ_reg <= occ_reg + 1'b1;
                2'b01:   occ_reg <= occ_reg - 1'b1;
                default: occ_reg <= occ_reg;
            endcase
            if ((out_pop && out_empty) || (wr_req && out_full)) begin
                error_reg <= 1'b1;
            end
        end
    end

    assign out_data  = out_empty ? '0 : head_reg;
    assign error     = error_reg;
    assign fwd_count = fwd_count_reg;

endmodule
